// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath.
// - aes_state_t / aes_col_t: 128-bit state and 32-bit column types
//   (column c = state[127-32c -: 32], row 0 = MSB byte of each column).
// - imc_state_e: control states of the iterative InvMixColumns block.
// - xtime() and the gf_mul_* helpers: GF(2^8) constant multiplies over
//   0x11B, built purely from xtime chains so no tables or multipliers appear.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } imc_state_e;

    // Multiply by x (0x02) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 0x09 = x^3 + 1
    function automatic logic [7:0] gf_mul_9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    // 0x0b = x^3 + x + 1
    function automatic logic [7:0] gf_mul_b(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    // 0x0d = x^3 + x^2 + 1
    function automatic logic [7:0] gf_mul_d(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    // 0x0e = x^3 + x^2 + x
    function automatic logic [7:0] gf_mul_e(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_column_calc.sv
// Combinational InvMixColumns of a single AES column.
// Ports:
//   col      in  32  input column, byte b0 (row 0) in bits [31:24]
//   col_out  out 32  transformed column, same byte layout
// r_i = 0e*b_i ^ 0b*b_(i+1) ^ 0d*b_(i+2) ^ 09*b_(i+3), indices mod 4.
module inv_mix_column_calc
    import aes_pkg::*;
(
    input  aes_col_t col,
    output aes_col_t col_out
);

    logic [7:0] b0_s;
    logic [7:0] b1_s;
    logic [7:0] b2_s;
    logic [7:0] b3_s;

    assign b0_s = col[31:24];
    assign b1_s = col[23:16];
    assign b2_s = col[15:8];
    assign b3_s = col[7:0];

    assign col_out[31:24] = gf_mul_e(b0_s) ^ gf_mul_b(b1_s) ^ gf_mul_d(b2_s) ^ gf_mul_9(b3_s);
    assign col_out[23:16] = gf_mul_e(b1_s) ^ gf_mul_b(b2_s) ^ gf_mul_d(b3_s) ^ gf_mul_9(b0_s);
    assign col_out[15:8]  = gf_mul_e(b2_s) ^ gf_mul_b(b3_s) ^ gf_mul_d(b0_s) ^ gf_mul_9(b1_s);
    assign col_out[7:0]   = gf_mul_e(b3_s) ^ gf_mul_b(b0_s) ^ gf_mul_d(b1_s) ^ gf_mul_9(b2_s);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: accepts one 128-bit state over in_valid/in_ready,
// transforms COLS_PER_CYCLE columns per clock (1, 2 or 4; N = 4/COLS_PER_CYCLE
// clocks), then presents the result over out_valid/out_ready.
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    in_data valid
//   in_ready   out  1    IDLE, or DONE with the result being taken this cycle
//   in_data    in   128  AES state
//   out_valid  out  1    out_data valid (held until out_ready)
//   out_ready  in   1    downstream accepts out_data
//   out_data   out  128  InvMixColumns(in_data)
//   busy       out  1    high in CALC or DONE
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // Column index of the first column of the final group; the 2-bit counter
    // wraps back to zero naturally when the step is added on that group.
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);

    imc_state_e  state_r;
    logic [1:0]  col_idx_r;
    aes_state_t  work_r;
    aes_state_t  next_work_s;
    logic        out_valid_r;
    aes_state_t  out_data_r;
    logic        busy_r;

    logic [1:0]  sel_s      [COLS_PER_CYCLE];
    aes_col_t    cur_col_s  [COLS_PER_CYCLE];
    aes_col_t    calc_col_s [COLS_PER_CYCLE];

    // One column datapath per column handled in a cycle; column c lives at
    // bit offset (3-c)*32, and 3-c of a 2-bit index is simply ~c.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gen_col
        assign sel_s[g]     = col_idx_r + 2'(g);
        assign cur_col_s[g] = work_r[{~sel_s[g], 5'd0} +: 32];

        inv_mix_column_calc u_calc (
            .col     (cur_col_s[g]),
            .col_out (calc_col_s[g])
        );
    end

    // Working state with the current group of columns replaced by their transform.
    always_comb begin
        next_work_s = work_r;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            next_work_s[{~sel_s[g], 5'd0} +: 32] = calc_col_s[g];
        end
    end

    // Ready is held low during reset so nothing is accepted on a reset edge.
    assign in_ready  = ~rst & ((state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready));
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

    // Control FSM, column counter, working register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            col_idx_r   <= 2'd0;
            work_r      <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_r    <= in_data;
                        col_idx_r <= 2'd0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_CALC;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    work_r    <= next_work_s;
                    col_idx_r <= col_idx_r + IDX_STEP;
                    if (col_idx_r == LAST_IDX) begin
                        out_data_r  <= next_work_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r     <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (in_valid) begin
                            // Result handed off and next block loaded on the same edge.
                            work_r    <= in_data;
                            col_idx_r <= 2'd0;
                            state_r   <= ST_CALC;
                        end else begin
                            busy_r    <= 1'b0;
                            state_r   <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    col_idx_r   <= 2'd0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule
